// File: rtl/press_evt_pkg.sv
package press_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_SINGLE = 2'b01,
    EVT_DOUBLE = 2'b10,
    EVT_LONG   = 2'b11
  } evt_code_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HELD1    = 3'd1,
    WAIT2    = 3'd2,
    HELD2    = 3'd3,
    LONGHOLD = 3'd4
  } state_t;

endpackage

// File: rtl/press_event_classifier_tick_prescaler.sv
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign TICK = (cnt == LAST);

  always_ff @(posedge CLK) begin
    if (RESET || TICK) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/press_event_classifier.sv
// Gesture classifier: SINGLE / DOUBLE / LONG. Define PRESS_EVT_REPEAT_EN
// for auto-repeat LONG events while the button stays held.
module press_event_classifier
  import press_evt_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned LONG_TICKS   = 500,
  parameter int unsigned DCLICK_TICKS = 250,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PRESS_VALID,
  input  logic       PRESS,
  input  logic       EVT_READY,
  output logic       EVT_VALID,
  output logic [1:0] EVT_CODE,
  output logic       DROP
);

  localparam int unsigned MAX_LD = (LONG_TICKS > DCLICK_TICKS) ? LONG_TICKS : DCLICK_TICKS;
  localparam int unsigned MAX_T  = (MAX_LD > REPEAT_TICKS) ? MAX_LD : REPEAT_TICKS;
  localparam int unsigned TW     = $clog2(MAX_T + 1);
  localparam logic [TW-1:0] LONG_T   = TW'(LONG_TICKS);
  localparam logic [TW-1:0] DCLICK_T = TW'(DCLICK_TICKS);
`ifdef PRESS_EVT_REPEAT_EN
  localparam logic [TW-1:0] REPEAT_T = TW'(REPEAT_TICKS);
`endif

  logic      tick;
  state_t    state, state_nx;
  logic [TW-1:0] timer;
  logic      emit;
  evt_code_t emit_code;
  logic      restart;
  evt_code_t evt_code;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .TICK  (tick)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    emit      = 1'b0;
    emit_code = EVT_NONE;
    restart   = 1'b0;
    case (state)
      IDLE: begin
        if (PRESS_VALID) state_nx = HELD1;
      end
      HELD1: begin
        if (PRESS) begin
          state_nx = WAIT2;
        end else if (timer >= LONG_T) begin
          emit      = 1'b1;
          emit_code = EVT_LONG;
          state_nx  = LONGHOLD;
        end
      end
      WAIT2: begin
        if (PRESS_VALID) begin
          emit      = 1'b1;
          emit_code = EVT_DOUBLE;
          state_nx  = HELD2;
        end else if (timer >= DCLICK_T) begin
          emit      = 1'b1;
          emit_code = EVT_SINGLE;
          state_nx  = IDLE;
        end
      end
      HELD2: begin
        if (PRESS) state_nx = IDLE;
      end
      LONGHOLD: begin
        if (PRESS) begin
          state_nx = IDLE;
        end
`ifdef PRESS_EVT_REPEAT_EN
        else if (timer >= REPEAT_T) begin
          emit      = 1'b1;
          emit_code = EVT_LONG;
          restart   = 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer <= '0;
    end else if ((state_nx != state) || restart) begin
      timer <= '0;
    end else if (tick && (timer != '1)) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      EVT_VALID <= 1'b0;
      evt_code  <= EVT_NONE;
      DROP      <= 1'b0;
    end else if (emit) begin
      if (!EVT_VALID || EVT_READY) begin
        EVT_VALID <= 1'b1;
        evt_code  <= emit_code;
      end else begin
        DROP <= 1'b1;
      end
    end else if (EVT_VALID && EVT_READY) begin
      EVT_VALID <= 1'b0;
      evt_code  <= EVT_NONE;
    end
  end

  assign EVT_CODE = evt_code;

endmodule
